// File: rtl/ofdm_data_descrambler_pkg.sv
// Shared definitions for the OFDM scrambler/descrambler pair: S(x) = x^7 + x^4 + 1.
package ofdm_data_descrambler_pkg;
  localparam int LFSR_W           = 7;
  localparam int TAP_HI           = 6;
  localparam int TAP_LO           = 3;
  localparam int SEED_BITS        = 7;
  localparam int SERVICE_BITS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_DATA    = 2'd3
  } state_e;

  function automatic logic scram_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction
endpackage

// File: rtl/ofdm_data_descrambler_if.sv
// Bit-serial stream between the RX decoder and the descrambler.
interface ofdm_data_descrambler_if;
  logic descram_din;
  logic descram_en;
  logic signal_flag_in;
  logic descram_dout;
  logic descram_vld;
  logic signal_flag_out;

  modport master (
    output descram_din, descram_en, signal_flag_in,
    input  descram_dout, descram_vld, signal_flag_out
  );

  modport slave (
    input  descram_din, descram_en, signal_flag_in,
    output descram_dout, descram_vld, signal_flag_out
  );
endinterface

// File: rtl/ofdm_data_descrambler_scram_lfsr7.sv
// 7-bit scrambler register: load-shift (seed recovery) or feedback-shift (run) mode.
module scram_lfsr7
  import ofdm_data_descrambler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              din_i,
  output logic [LFSR_W-1:0] state_o,
  output logic              fb_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  assign fb_o    = scram_fb(state_q);
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (clr_i)       state_d = '0;
    else if (load_i) state_d = {state_q[LFSR_W-2:0], din_i};
    else if (step_i) state_d = {state_q[LFSR_W-2:0], fb_o};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/ofdm_data_descrambler.sv
// RX descrambler: recovers the TX scrambler state from the zero seed bits, then descrambles SERVICE+PSDU.
// state   | meaning
// IDLE    | no frame, non-SIGNAL bits dropped
// SEED    | shifting received bits straight into the LFSR
// SERVICE | descrambling reserved SERVICE bits, any 1 flags service_err
// DATA    | descrambling PSDU, frame_done on bit data_len
module ofdm_data_descrambler
  import ofdm_data_descrambler_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int SERVICE_BITS = SERVICE_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_clr_i,
  input  logic [LEN_W-1:0]       data_len_i,
  ofdm_data_descrambler_if.slave bit_if,
  output logic [LFSR_W-1:0]      lfsr_state_o,
  output logic                   seed_vld_o,
  output logic                   service_err_o,
  output logic                   frame_done_o
);

  localparam int SVC_W = $clog2(SERVICE_BITS + 1);
  localparam logic [SVC_W-1:0] SEED_LAST = SVC_W'(SEED_BITS - 1);
  localparam logic [SVC_W-1:0] SVC_LAST  = SVC_W'(SERVICE_BITS - 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] dat_cnt_q, dat_cnt_d;
  logic [SVC_W-1:0] svc_cnt_q, svc_cnt_d;
  logic dout_q, dout_d;
  logic vld_q, vld_d;
  logic sflag_q;
  logic seed_vld_q, seed_vld_d;
  logic serr_q, serr_d;
  logic done_q, done_d;
  logic lfsr_clr, lfsr_load, lfsr_step;
  logic lfsr_fb;
  logic plain_bit;

  scram_lfsr7 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (lfsr_clr),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .din_i   (bit_if.descram_din),
    .state_o (lfsr_state_o),
    .fb_o    (lfsr_fb)
  );

  assign plain_bit = bit_if.descram_din ^ lfsr_fb;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    dat_cnt_d  = dat_cnt_q;
    svc_cnt_d  = svc_cnt_q;
    dout_d     = 1'b0;
    vld_d      = 1'b0;
    seed_vld_d = 1'b0;
    serr_d     = serr_q;
    done_d     = 1'b0;
    lfsr_clr   = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    if (rx_clr_i) begin
      state_d   = ST_SEED;
      len_d     = data_len_i;
      dat_cnt_d = '0;
      svc_cnt_d = '0;
      serr_d    = 1'b0;
      lfsr_clr  = 1'b1;
    end else if (bit_if.descram_en) begin
      if (bit_if.signal_flag_in) begin
        dout_d = bit_if.descram_din;
        vld_d  = 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_SEED: begin
            lfsr_load = 1'b1;
            vld_d     = 1'b1;
            svc_cnt_d = svc_cnt_q + 1'b1;
            if (svc_cnt_q == SEED_LAST) begin
              seed_vld_d = 1'b1;
              state_d    = ST_SERVICE;
            end
          end
          ST_SERVICE: begin
            lfsr_step = 1'b1;
            dout_d    = plain_bit;
            vld_d     = 1'b1;
            svc_cnt_d = svc_cnt_q + 1'b1;
            if (plain_bit) serr_d = 1'b1;
            if (svc_cnt_q == SVC_LAST) begin
              if (len_q == '0) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_DATA;
              end
            end
          end
          ST_DATA: begin
            lfsr_step = 1'b1;
            dout_d    = plain_bit;
            vld_d     = 1'b1;
            dat_cnt_d = dat_cnt_q + 1'b1;
            if (dat_cnt_q == len_q - 1'b1) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      dat_cnt_q  <= '0;
      svc_cnt_q  <= '0;
      dout_q     <= 1'b0;
      vld_q      <= 1'b0;
      sflag_q    <= 1'b0;
      seed_vld_q <= 1'b0;
      serr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      dat_cnt_q  <= dat_cnt_d;
      svc_cnt_q  <= svc_cnt_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      sflag_q    <= bit_if.signal_flag_in;
      seed_vld_q <= seed_vld_d;
      serr_q     <= serr_d;
      done_q     <= done_d;
    end
  end

  assign bit_if.descram_dout    = dout_q;
  assign bit_if.descram_vld     = vld_q;
  assign bit_if.signal_flag_out = sflag_q;
  assign seed_vld_o             = seed_vld_q;
  assign service_err_o          = serr_q;
  assign frame_done_o           = done_q;

endmodule

// File: tb/tb_ofdm_data_descrambler.sv
// Scoreboard bench for ofdm_data_descrambler: stimulus pushes expected bits, a negedge monitor pops and compares.
module tb_ofdm_data_descrambler;
  localparam int LEN_W = 16;

  typedef struct packed {
    logic dout;
    logic sig;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_clr = 1'b0;
  logic [LEN_W-1:0] data_len = '0;
  logic [6:0] lfsr_state;
  logic seed_vld, service_err, frame_done;

  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  int n_vld = 0;
  int vld_base;
  logic [6:0] tx_st;
  logic [255:0] psdu;

  ofdm_data_descrambler_if bit_if ();

  always #5 clk = ~clk;

  ofdm_data_descrambler #(.LEN_W(LEN_W), .SERVICE_BITS(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_clr_i      (rx_clr),
    .data_len_i    (data_len),
    .bit_if        (bit_if),
    .lfsr_state_o  (lfsr_state),
    .seed_vld_o    (seed_vld),
    .service_err_o (service_err),
    .frame_done_o  (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bit_if.descram_vld === 1'b1) begin
      n_vld++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_vld: got vld=1 dout=%0b expected no output (t=%0t)",
                 bit_if.descram_dout, $time);
      end else begin
        mon_e = q.pop_front();
        chk("dout", {31'b0, bit_if.descram_dout}, {31'b0, mon_e.dout});
        chk("signal_flag_out", {31'b0, bit_if.signal_flag_out}, {31'b0, mon_e.sig});
        chk("frame_done", {31'b0, frame_done}, {31'b0, mon_e.done});
      end
    end else if (!rst) begin
      chk("done_without_vld", {31'b0, frame_done}, 32'd0);
    end
  end

  task automatic expect_bit(input logic d, input logic s, input logic dn);
    q.push_back({d, s, dn});
  endtask

  task automatic step(input logic en, input logic din, input logic sig);
    bit_if.descram_en     = en;
    bit_if.descram_din    = din;
    bit_if.signal_flag_in = sig;
    @(posedge clk);
    #1;
    bit_if.descram_en     = 1'b0;
    bit_if.signal_flag_in = 1'b0;
  endtask

  task automatic tx_scr(input logic d, output logic s);
    logic fb;
    fb    = tx_st[6] ^ tx_st[3];
    s     = d ^ fb;
    tx_st = {tx_st[5:0], fb};
  endtask

  // rx_clr with a simultaneous bit: the bit must be dropped
  task automatic start_frame(input int len);
    data_len = LEN_W'(len);
    rx_clr   = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rx_clr   = 1'b0;
    chk("clr_service_err", {31'b0, service_err}, 32'd0);
    chk("clr_lfsr", {25'b0, lfsr_state}, 32'd0);
  endtask

  task automatic send_frame(input logic [6:0] seed, input int len, input int nbits,
                            input int flip_idx, input int max_gap);
    logic s, d, e;
    tx_st = seed;
    for (int i = 0; i < nbits; i++) begin
      d = (i < 16) ? 1'b0 : psdu[i-16];
      tx_scr(d, s);
      if (i == flip_idx) s = ~s;
      if (i < 7)       e = 1'b0;
      else if (i < 16) e = (i == flip_idx);
      else             e = d;
      expect_bit(e, 1'b0, (i == 16 + len - 1));
      step(1'b1, s, 1'b0);
      if (i == 6) chk("seed_vld_pulse", {31'b0, seed_vld}, 32'd1);
      if (i == 7) chk("seed_vld_low", {31'b0, seed_vld}, 32'd0);
      if (i >= 6) chk("lfsr_state", {25'b0, lfsr_state}, {25'b0, tx_st});
      chk("service_err", {31'b0, service_err},
          {31'b0, (flip_idx >= 0 && flip_idx < 16 && i >= flip_idx)});
      repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    bit_if.descram_en     = 1'b0;
    bit_if.descram_din    = 1'b0;
    bit_if.signal_flag_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'b0, bit_if.descram_vld}, 32'd0);
    chk("rst_dout", {31'b0, bit_if.descram_dout}, 32'd0);
    chk("rst_sflag", {31'b0, bit_if.signal_flag_out}, 32'd0);
    chk("rst_lfsr", {25'b0, lfsr_state}, 32'd0);
    chk("rst_seed_vld", {31'b0, seed_vld}, 32'd0);
    chk("rst_service_err", {31'b0, service_err}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    rst = 1'b0;

    // SIGNAL-field bypass before any frame, then a dropped non-SIGNAL bit in IDLE
    for (int i = 0; i < 24; i++) begin
      expect_bit(1'((i + 1) % 2), 1'b1, 1'b0);
      step(1'b1, 1'((i + 1) % 2), 1'b1);
    end
    chk("signal_lfsr_unchanged", {25'b0, lfsr_state}, 32'd0);
    step(1'b1, 1'b1, 1'b0);

    // Seed 7F, PSDU A5 LSB first; recovered state must be 0000111
    psdu = '0;
    psdu[7:0] = 8'hA5;
    start_frame(8);
    send_frame(7'h7F, 8, 7, -1, 0);
    chk("seed_state_7f", {25'b0, lfsr_state}, 32'h07);
    send_frame_tail();
    chk("svc_err_clean", {31'b0, service_err}, 32'd0);

    // Same frame with SERVICE bit 10 corrupted
    start_frame(8);
    send_frame(7'h7F, 8, 24, 9, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("svc_err_sticky", {31'b0, service_err}, 32'd1);

    // Abort after 3 PSDU bits, then a fresh frame with seed 1011101
    psdu[7:0] = 8'h5A;
    start_frame(8);
    send_frame(7'h7F, 8, 19, -1, 0);
    psdu[7:0] = 8'h3C;
    start_frame(8);
    send_frame(7'b1011101, 8, 24, -1, 0);

    // 100-bit PSDU with random enable gaps
    for (int i = 0; i < 100; i++) psdu[i] = 1'($urandom);
    step(1'b0, 1'b0, 1'b0);
    vld_base = n_vld;
    start_frame(100);
    send_frame(7'h55, 100, 116, -1, 5);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("gap_vld_count", n_vld - vld_base, 32'd116);

    // Zero-length PSDU: done with the 16th bit, then IDLE drops bits
    start_frame(0);
    send_frame(7'h2A, 0, 16, -1, 0);
    step(1'b1, 1'b1, 1'b0);

    // Async reset in the middle of SERVICE
    start_frame(8);
    send_frame(7'h33, 8, 10, -1, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_vld", {31'b0, bit_if.descram_vld}, 32'd0);
    chk("arst_lfsr", {25'b0, lfsr_state}, 32'd0);
    chk("arst_sflag", {31'b0, bit_if.signal_flag_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_lfsr", {25'b0, lfsr_state}, 32'd0);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Continues the 7F/A5 frame after the seed bits were checked against the hand-derived state
  task automatic send_frame_tail();
    logic s, d, e;
    for (int i = 7; i < 24; i++) begin
      d = (i < 16) ? 1'b0 : psdu[i-16];
      tx_scr(d, s);
      e = (i < 16) ? 1'b0 : d;
      expect_bit(e, 1'b0, (i == 23));
      step(1'b1, s, 1'b0);
      chk("lfsr_state", {25'b0, lfsr_state}, {25'b0, tx_st});
    end
  endtask

endmodule

// File: doc/ofdm_data_descrambler.md
Name: ofdm_data_descrambler

Overview:
Receive-side counterpart of the TX data scrambler, using the same S(x) = x^7 + x^4 + 1 polynomial. Sits after the RX deinterleaver/Viterbi output in the OFDM RX data path, bit-serial at the 20 MHz sample clock. Recovers the TX scrambler state from the first 7 SERVICE bits, which are all zero, and then descrambles the rest of SERVICE and the PSDU. Also checks the reserved SERVICE bits, counts PSDU bits and signals end of frame. SIGNAL-field bits bypass the descrambler untouched.

Parameters:
LEN_W, 16, width of data_len (PSDU length in bits)
SERVICE_BITS, 16, SERVICE field length in bits (7 seed bits + reserved bits); must be > 7

Ports:
clk  in  1  20 MHz clock
rst  in  1  asynchronous active-high reset
rx_clr  in  1  start-of-frame pulse: latch data_len, clear state, enter SEED
data_len  in  LEN_W  PSDU length in bits, sampled when rx_clr=1
descram_din  in  1  received scrambled bit
descram_en  in  1  descram_din valid this cycle
signal_flag_in  in  1  current bit belongs to the SIGNAL field (bypass)
descram_dout  out  1  descrambled bit
descram_vld  out  1  descram_dout valid (one-cycle pulse per accepted bit)
signal_flag_out  out  1  registered copy of signal_flag_in, aligned with dout
lfsr_state  out  7  recovered scrambler register, valid from seed_vld onward
seed_vld  out  1  one-cycle pulse when 7th seed bit loaded
service_err  out  1  sticky: a reserved SERVICE bit descrambled to 1; cleared by rx_clr
frame_done  out  1  one-cycle pulse with the last PSDU bit's descram_vld

Behaviour:
- Reset (rst=1, async): all outputs 0, lfsr=0, counters=0, state=IDLE.
- Latency is 1 cycle for all bit outputs: registered on the clk edge after descram_en.
- Priority per cycle: rst > rx_clr > descram_en. rx_clr with descram_en in the same cycle drops the bit (vld=0).
- rx_clr in any state aborts the current frame: no frame_done; service_err, lfsr and counters cleared; state=SEED.
- descram_en=1, signal_flag_in=1, any state: dout=din, vld=1. LFSR, counters and state are unchanged.
- signal_flag_out: registered signal_flag_in every cycle, regardless of en.
- States (for non-signal bits with en=1):
  - IDLE: bit dropped, vld=0.
  - SEED: lfsr <= {lfsr[5:0], din}; dout=0, vld=1; cnt++. On the 7th bit: seed_vld=1 and go to SERVICE. The lfsr then equals the TX register state, because data=0 makes the scrambled bit equal to the feedback bit.
  - SERVICE: fb = lfsr[6]^lfsr[3]; dout = din^fb; lfsr <= {lfsr[5:0], fb}; vld=1. If dout=1, set service_err. After bit SERVICE_BITS: go to DATA. If data_len=0, pulse frame_done with the last SERVICE bit and go to IDLE.
  - DATA: same descramble as SERVICE, no error check; bit counter counts 1..data_len. On bit data_len: frame_done=1 with the same vld, then IDLE.
- No back-pressure: en gaps of any length are tolerated and hold all state.
- Bit counter is LEN_W bits wide and does not wrap: data_len = 2^LEN_W-1 is legal.
- lfsr_state output is continuously driven from the internal register.

Decomposition:
- Shared ofdm package: SCRAM_POLY taps (6,3), LFSR width 7, SERVICE_BITS default, state encoding enum {IDLE, SEED, SERVICE, DATA}.
- One natural sub-module: scram_lfsr7 (load-shift / feedback-shift modes, exposes fb and state). The TX scrambler can share it later.
- FSM and counters stay in the top module.

Test Plan:
- TX seed 7'b1111111, all-zero SERVICE plus 8-bit PSDU 8'hA5; feed scrambled stream (begins 0000111 0111100101...) -> seed_vld after 7th bit, lfsr_state=7'b0000111, 9 zero SERVICE outputs, dout=A5 bit sequence, frame_done on 24th vld, service_err=0.
- 24 SIGNAL bits with signal_flag_in=1 before rx_clr, din=101... -> dout identical, signal_flag_out=1 aligned, lfsr_state unchanged at 0.
- Same frame as test 1 with SERVICE bit 10 flipped -> service_err rises 1 cycle after that bit, stays 1 through frame_done, cleared by next rx_clr.
- rx_clr asserted mid-DATA (after 3 PSDU bits), then a new frame with seed 7'b1011101 -> no frame_done for the first frame; second frame descrambles correctly.
- Random en gaps (0-5 idle cycles between bits), data_len=100 -> output bit stream identical to gapless run, exactly 116 vld pulses.
- data_len=0 -> frame_done coincides with 16th vld; rst pulsed mid-SERVICE -> all outputs 0 immediately, next non-signal bit dropped.
